// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The bench drives the master side and the adder sits on the slave side.
interface serial_adder_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             busy;
  logic             done;

  modport master (output start, a, b, cin, input s, cout, busy, done);
  modport slave  (input start, a, b, cin, output s, cout, busy, done);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,s} = a + b + cin, one bit per clock, LSB first,
// through a single full-adder slice and a carry flop.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             last_bit;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;

  logic             sum_bit;
  logic             carry_next;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  // Full-adder slice always works on the current LSB of the shifting operands.
  assign sum_bit    = fa_sum(op_a[0], op_b[0], carry);
  assign carry_next = fa_carry(op_a[0], op_b[0], carry);
  assign last_bit   = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result is assembled MSB-in so that after WIDTH shifts bit 0 lands at position 0;
  // s/cout only update on the final bit so partial sums are never visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry    <= 1'b0;
      cnt      <= '0;
      s_reg    <= '0;
      cout_reg <= 1'b0;
    end else if (load) begin
      op_a  <= bus.a;
      op_b  <= bus.b;
      carry <= bus.cin;
      cnt   <= '0;
    end else if (step) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      res   <= {sum_bit, res[WIDTH-1:1]};
      carry <= carry_next;
      cnt   <= cnt + CNT_W'(1);
      if (last_bit) begin
        s_reg    <= {sum_bit, res[WIDTH-1:1]};
        cout_reg <= carry_next;
      end
    end
  end

  assign bus.s    = s_reg;
  assign bus.cout = cout_reg;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed scenarios plus a shuffled sweep of
// all 512 four-bit operand/carry combinations checked against plain a+b+cin.
module tb_serial_adder;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc_cnt = 0;
  logic [W:0] last_res;
  logic [W:0] exp_q[$];
  int   done_times[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int total;
    total = int'(x) + int'(y) + int'(c);
    return (W+1)'(total);
  endfunction

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_times.push_back(cyc_cnt);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result", 32'({bus.cout, bus.s}), 32'(e));
        last_res = e;
      end
    end
  end

  // Called at a negedge with the adder idle; accept happens on the next posedge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input bit push, input bit keep_start);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    bus.cin   = c;
    if (push) exp_q.push_back(ref_add(x, y, c));
    @(negedge clk);
    if (!keep_start) bus.start = 1'b0;
  endtask

  // mode 0: quiet inputs, 1: random noise on inputs, 2: late start with new operands.
  task automatic wait_run(input int mode);
    int cyc = 0;
    while (bus.busy && cyc < 3 * W) begin
      check("hold_during_run", 32'({bus.cout, bus.s}), 32'(last_res));
      if (mode == 1) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom_range(0, 1));
      end else if (mode == 2 && cyc == 2) begin
        bus.start = 1'b1;
        bus.a     = 4'b0001;
        bus.b     = 4'b0001;
        bus.cin   = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(cyc), 32'(W));
    check("done_pulse", 32'(bus.done), 32'd1);
  endtask

  task automatic idle_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      check("stay_idle", 32'({bus.busy, bus.done}), 32'd0);
      @(negedge clk);
    end
  endtask

  int idx[512];

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    last_res  = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s", 32'(bus.s), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic add.
    launch(4'b0011, 4'b0101, 1'b0, 1, 0);
    wait_run(0);
    @(negedge clk);
    check("basic_hold_idle", 32'({bus.cout, bus.s}), 32'b0_1000);

    // Overflow cases.
    launch(4'b1111, 4'b0001, 1'b0, 1, 0);
    wait_run(0);
    @(negedge clk);
    launch(4'b1111, 4'b1111, 1'b1, 1, 0);
    wait_run(0);
    @(negedge clk);

    // Start during RUN must be ignored; drop it at DONE so nothing relaunches.
    launch(4'b1100, 4'b0011, 1'b0, 1, 0);
    wait_run(2);
    bus.start = 1'b0;
    @(negedge clk);
    idle_quiet(W + 2);
    check("ignore_result", 32'({bus.cout, bus.s}), 32'b0_1111);

    // Reset in the second RUN cycle aborts with no done pulse.
    launch(4'b1010, 4'b0101, 1'b1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    check("abort_s", 32'(bus.s), 32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    idle_quiet(W + 3);

    // Back-to-back with start held high.
    done_times.delete();
    launch(4'b1001, 4'b0110, 1'b1, 1, 1);
    wait_run(0);
    bus.a   = 4'b0000;
    bus.b   = 4'b0000;
    bus.cin = 1'b0;
    exp_q.push_back(ref_add(4'b0000, 4'b0000, 1'b0));
    @(negedge clk);
    wait_run(0);
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b_count", 32'(done_times.size()), 32'd2);
    if (done_times.size() == 2)
      check("b2b_spacing", 32'(done_times[1] - done_times[0]), 32'(W + 1));

    // Shuffled sweep of every a/b/cin combination with noisy inputs while busy.
    for (int i = 0; i < 512; i++) idx[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(0, i));
      t = idx[i];
      idx[i] = idx[j];
      idx[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(idx[i]);
      launch(v[3:0], v[7:4], v[8], 1, 0);
      wait_run(1);
      bus.start = 1'b0;
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule
